bit_deframer: RTL and testbench
===============================

BIT_DEFRAMER -- requirements
Module: bit_deframer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hA5, the 8-bit frame sync pattern.
REQ-002 SHALL have parameter FRAME_BYTES, default 16, the payload bytes per frame (legal range 1..255).
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port data_in  input  1  descrambled serial bit from the descrambler stage.
REQ-006 SHALL have port bit_en  input  1  data_in is sampled only on edges where bit_en=1.
REQ-007 SHALL have port out_ready  input  1  downstream accepts out_byte when high with out_valid.
REQ-008 SHALL have port out_byte  output  8  assembled payload byte; first received bit is bit 7 (MSB first).
REQ-009 SHALL have port out_valid  output  1  out_byte, frame_start and frame_end are valid.
REQ-010 SHALL have port frame_start  output  1  qualifies out_byte as byte 0 of a frame.
REQ-011 SHALL have port frame_end  output  1  qualifies out_byte as byte FRAME_BYTES-1 of a frame.
REQ-012 SHALL have port locked  output  1  high while in PAYLOAD state.
REQ-013 SHALL have port overrun  output  1  sticky flag; a completed byte was dropped.

Function
REQ-014 SHALL implement two states: HUNT and PAYLOAD.
REQ-015 In HUNT, SHALL shift data_in into an 8-bit history register on each bit_en edge (new bit into LSB).
REQ-016 In HUNT, SHALL transition to PAYLOAD on the edge whose shifted-in bit makes the history equal SYNC_WORD; that bit is not payload.
REQ-017 On entering HUNT, SHALL clear the history register to 8'h00, so a new sync needs 8 fresh bits; with SYNC_WORD=8'h00 the bits still must all be received.
REQ-018 In PAYLOAD, SHALL ignore sync matches and pack bits into a byte, MSB first, with a 3-bit bit counter and an 8-bit byte counter.
REQ-019 SHALL complete a byte on the edge sampling its 8th bit; out_valid SHALL be high from the following cycle (1-cycle latency).
REQ-020 SHALL assert frame_start with byte 0 and frame_end with byte FRAME_BYTES-1; both with FRAME_BYTES=1.
REQ-021 After completing byte FRAME_BYTES-1, SHALL return to HUNT on the same edge; locked SHALL drop the next cycle.
REQ-022 out_valid SHALL remain high, and out_byte/frame_start/frame_end stable, until an edge with out_valid=1 and out_ready=1.
REQ-023 If a byte completes while out_valid=1 and out_ready=0, SHALL drop the new byte, keep the held byte, and set overrun; the byte counter still advances.
REQ-024 If a byte completes on the same edge as a handshake, SHALL load the new byte with out_valid staying high and SHALL NOT set overrun.
REQ-025 bit_en=0 SHALL freeze the history register, bit counter, byte counter and state; the output handshake SHALL still operate.
REQ-026 overrun SHALL clear only on reset.

Reset
REQ-027 While Reset=0, SHALL asynchronously force: state HUNT, history 8'h00, counters 0, out_byte 8'h00, out_valid 0, frame_start 0, frame_end 0, locked 0, overrun 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial byte and any held output byte.
REQ-029 After Reset deasserts, sampling SHALL begin on the first rising edge with bit_en=1.

Verification
REQ-030 Stream with bit_en=1 and out_ready=1: 8'hA5, then 16 bytes 8'h00..8'h0F. Required: 16 out_valid pulses with bytes 00..0F, frame_start with 00, frame_end with 0F, overrun 0.
REQ-031 Stream 8'hA5 inside payload byte 3, then a second sync after the frame. Required: the inner A5 is emitted as data and the second frame locks correctly.
REQ-032 Hold out_ready=0 across two byte completions. Required: first byte held, second dropped, overrun=1; after out_ready=1 the first byte transfers once.
REQ-033 Toggle bit_en every other cycle through a full frame. Required: output bytes identical to REQ-030; each out_valid 1 cycle after its 8th enabled edge.
REQ-034 Pull Reset low after 4 payload bytes, release, then resend the full sync+frame. Required: all outputs 0 during reset, no stale byte, clean 16-byte frame after.
REQ-035 FRAME_BYTES=1, stream A5 then 3C. Required: a single out_valid with 8'h3C and frame_start=frame_end=1.

Source files
------------

// File: rtl/bit_deframer.sv
// bit_deframer: serial bit stream deframer.
// Hunts for an 8-bit sync pattern, then packs the next FRAME_BYTES bytes
// (MSB first) and presents them on a valid/ready byte interface.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous active-low reset
//   data_in     in   serial bit, sampled only when bit_en=1
//   bit_en      in   bit strobe
//   out_ready   in   downstream accepts out_byte while out_valid=1
//   out_byte    out  assembled payload byte
//   out_valid   out  out_byte / frame_start / frame_end are valid
//   frame_start out  out_byte is byte 0 of the frame
//   frame_end   out  out_byte is the last byte of the frame
//   locked      out  high while in PAYLOAD
//   overrun     out  sticky: a completed byte was dropped (cleared by reset)
module bit_deframer #(
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         FRAME_BYTES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       data_in,
  input  logic       bit_en,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       locked,
  output logic       overrun
);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  state_t     state;
  logic [7:0] history;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;

  logic [7:0] hist_next;
  logic [7:0] cpl_byte;
  logic       sync_hit;
  logic       complete;
  logic       last_byte;
  logic       load;

  always_comb begin
    hist_next = {history[6:0], data_in};
    cpl_byte  = {shreg[6:0], data_in};
    // In HUNT bit_cnt counts fill bits (saturating at 7) so a match needs
    // eight fresh bits even when SYNC_WORD equals the cleared history.
    sync_hit  = (bit_cnt == 3'd7) && (hist_next == SYNC_WORD);
    complete  = bit_en && (state == PAYLOAD) && (bit_cnt == 3'd7);
    last_byte = (byte_cnt == LAST_IDX);
    load      = complete && (!out_valid || out_ready);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= HUNT;
      history     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      out_byte    <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              state    <= PAYLOAD;
              history  <= '0;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              shreg    <= '0;
            end else begin
              history <= hist_next;
              if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PAYLOAD: begin
            shreg   <= cpl_byte;
            // Wraps 7 -> 0 on byte completion, which also restarts the
            // HUNT fill count when the frame ends.
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (last_byte) begin
                state    <= HUNT;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end

      if (load) begin
        out_byte    <= cpl_byte;
        out_valid   <= 1'b1;
        frame_start <= (byte_cnt == 8'd0);
        frame_end   <= last_byte;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
        frame_start <= 1'b0;
        frame_end   <= 1'b0;
      end
    end
  end

  assign locked = (state == PAYLOAD);

endmodule

// File: tb/tb_bit_deframer.sv
// tb_bit_deframer: scoreboard bench for bit_deframer (default 16-byte frame)
// plus a second instance configured for single-byte frames.
module tb_bit_deframer;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, data_in, bit_en, out_ready;
  logic [7:0] out_byte;
  logic       out_valid, frame_start, frame_end, locked, overrun;

  logic       rst1, data1, en1, ready1;
  logic [7:0] byte1;
  logic       valid1, start1, end1, locked1, overrun1;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   pulses1 = 0;

  always #5 clk = ~clk;

  bit_deframer dut (
    .Clk(clk), .Reset(rst_n), .data_in(data_in), .bit_en(bit_en),
    .out_ready(out_ready), .out_byte(out_byte), .out_valid(out_valid),
    .frame_start(frame_start), .frame_end(frame_end), .locked(locked),
    .overrun(overrun)
  );

  bit_deframer #(.FRAME_BYTES(1)) dut1 (
    .Clk(clk), .Reset(rst1), .data_in(data1), .bit_en(en1),
    .out_ready(ready1), .out_byte(byte1), .out_valid(valid1),
    .frame_start(start1), .frame_end(end1), .locked(locked1),
    .overrun(overrun1)
  );

  // Output monitor: every accepted byte must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      exp_t got;
      vectors++;
      got = {out_byte, frame_start, frame_end};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got byte=%h start=%b end=%b, required none",
                 out_byte, frame_start, frame_end);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out_byte: got byte=%h start=%b end=%b, required byte=%h start=%b end=%b",
                   out_byte, frame_start, frame_end, e.data, e.first, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst1 && valid1 && ready1) pulses1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    step();
    data_in = b;
    bit_en  = 1'b1;
    if (gap) begin
      step();
      bit_en = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap, input bit lat);
    for (int unsigned i = 0; i < 8; i++) send_bit(v[7-i], gap);
    if (lat) begin
      vectors++;
      if (out_valid !== 1'b1 || out_byte !== v) begin
        errors++;
        $display("FAIL latency: got valid=%b byte=%h, required valid=1 byte=%h",
                 out_valid, out_byte, v);
      end
    end
  endtask

  task automatic idle();
    step();
    bit_en = 1'b0;
  endtask

  task automatic send_sync(input bit gap);
    send_byte(8'hA5, gap, 1'b0);
    idle();
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_sync: got locked=%b, required 1", locked);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gap, input bit a5_at3);
    logic [7:0] v;
    for (int unsigned idx = 0; idx < 16; idx++) begin
      v = (a5_at3 && idx == 3) ? 8'hA5 : base + 8'(idx);
      exp_q.push_back({v, idx == 0, idx == 15});
      send_byte(v, gap, gap);
    end
    idle();
    vectors++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL unlock_after_frame: got locked=%b, required 0", locked);
    end
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 50 && exp_q.size() != 0; i++) step();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending bytes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({out_byte, out_valid, frame_start, frame_end, locked, overrun} !== 13'd0) begin
      errors++;
      $display("FAIL %s: got byte=%h valid=%b start=%b end=%b locked=%b overrun=%b, required all 0",
               name, out_byte, out_valid, frame_start, frame_end, locked, overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = 1'b0; bit_en = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    step();
    check_outputs_zero("after_release");
  endtask

  task automatic test_basic_frame();
    // Leading noise in HUNT must not lock.
    send_byte(8'h3C, 1'b0, 1'b0);
    send_sync(1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    drain();
    vectors++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_inner_sync();
    send_sync(1'b0);
    send_frame(8'h40, 1'b0, 1'b1);
    send_sync(1'b0);
    send_frame(8'h80, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_bit_en_toggle();
    send_sync(1'b1);
    send_frame(8'h00, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_overrun();
    send_sync(1'b0);
    out_ready = 1'b0;
    exp_q.push_back({8'h11, 1'b1, 1'b0});
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    idle();
    vectors++;
    if ({out_valid, out_byte, overrun} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b byte=%h overrun=%b, required valid=1 byte=11 overrun=1",
               out_valid, out_byte, overrun);
    end
    out_ready = 1'b1;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: got valid=%b, required 0", out_valid);
    end
    for (int unsigned idx = 2; idx < 16; idx++) begin
      exp_q.push_back({8'h20 + 8'(idx), 1'b0, idx == 15});
      send_byte(8'h20 + 8'(idx), 1'b0, 1'b0);
    end
    idle();
    drain();
    vectors++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_mid_reset();
    send_sync(1'b0);
    for (int unsigned idx = 0; idx < 4; idx++) begin
      exp_q.push_back({8'hC0 + 8'(idx), idx == 0, 1'b0});
      send_byte(8'hC0 + 8'(idx), 1'b0, 1'b0);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle();
    drain();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    step();
    check_outputs_zero("mid_reset_hold");
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send_sync(1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_single_byte_frame();
    logic [15:0] s;
    s = 16'hA53C;
    rst1 = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      step();
      data1 = s[15-i];
      en1 = 1'b1;
    end
    step();
    en1 = 1'b0;
    vectors++;
    if ({valid1, byte1, start1, end1, locked1} !== {1'b1, 8'h3C, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_frame: got valid=%b byte=%h start=%b end=%b locked=%b, required 1 3c 1 1 0",
               valid1, byte1, start1, end1, locked1);
    end
    repeat (4) step();
    vectors++;
    if (pulses1 != 1 || overrun1 !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got pulses=%0d overrun=%b, required 1 and 0", pulses1, overrun1);
    end
  endtask

  initial begin
    rst1 = 1'b0; data1 = 1'b0; en1 = 1'b0; ready1 = 1'b1;
    test_reset();
    test_basic_frame();
    test_inner_sync();
    test_bit_en_toggle();
    test_overrun();
    test_reset();
    test_mid_reset();
    test_single_byte_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
